uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller that sequences and buffers the UART character recovery block. It holds the recovery block in reset until the line has been idle long enough to guarantee character alignment. It then accepts recovered characters into a small FIFO and presents them to the consumer over a valid/ready handshake. Framing, parity and overrun conditions are collected as sticky status flags.

## Interface
- `DATA_BITS`, 8, character width; must match the recovery block.
- `FIFO_DEPTH`, 4, entries; power of two, ≥2.
- `ARM_CYCLES`, 160, consecutive high `rx_i` cycles required before the receiver is released (10 bit times at 16× oversampling); ≥2.

- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  receiver enable (level).
- `flush_i`  in  1  single-cycle FIFO flush.
- `clear_i`  in  1  single-cycle clear of sticky flags (and counters).
- `rx_i`  in  1  synchronized serial line, same signal fed to the recovery block.
- `char_i`  in  DATA_BITS  recovered character.
- `valid_i`  in  1  one-cycle pulse: good character on `char_i`.
- `frame_error_i`  in  1  one-cycle pulse: stop bit low.
- `parity_error_i`  in  1  one-cycle pulse: parity mismatch.
- `rx_rst_o`  out  1  synchronous active-high reset to the recovery block.
- `data_o`  out  DATA_BITS  FIFO head.
- `data_valid_o`  out  1  FIFO not empty.
- `data_ready_i`  in  1  consumer accepts head.
- `level_o`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overrun_o`, `frame_err_o`, `parity_err_o`  out  1 each  sticky status.
- `frame_cnt_o`, `parity_cnt_o`, `overrun_cnt_o`  out  8 each  error counters (see Configuration).

## Operation
- States: DISABLED, ARM, RUN.
- DISABLED:
  - `rx_rst_o`=1; all `valid_i`/error pulses are ignored.
  - `enable_i`=1 → ARM; idle counter loads 0.
- ARM:
  - `rx_rst_o`=1.
  - `rx_i`=0 → counter reset to 0; `rx_i`=1 → counter +1.
  - Counter == ARM_CYCLES-1 with `rx_i`=1 → RUN.
  - `enable_i`=0 → DISABLED.
- RUN:
  - `rx_rst_o`=0.
  - `enable_i`=0 → DISABLED on the next edge. Any character in flight is abandoned; no partial write.
- FIFO push: `valid_i` in RUN.
  - If full and not popping in the same cycle: the character is dropped and `overrun_o` is set.
  - Full with a simultaneous pop: push accepted, level unchanged.
- FIFO pop: `data_valid_o && data_ready_i`.
  - Pop has no effect on an empty FIFO.
  - Pointers wrap modulo FIFO_DEPTH; `level_o` saturates exactly at FIFO_DEPTH.
- `flush_i`: pointers and level go to 0. Flush takes priority over a same-cycle push and pop; the pushed character is discarded with no overrun. Flush does not change state.
- Sticky flags:
  - `frame_error_i`/`parity_error_i` in RUN set `frame_err_o`/`parity_err_o`.
  - `clear_i` clears all three flags.
  - A set and a clear in the same cycle: set wins.
- FIFO contents remain readable in DISABLED and ARM.

## Timing
- Reset (asynchronous assert, clocked release): state DISABLED, `rx_rst_o`=1, `data_o`=0, `data_valid_o`=0, `level_o`=0, all flags 0, all counters 0.
- `valid_i` at edge N into an empty FIFO → `data_valid_o`=1 and `data_o`=char after edge N (one cycle latency, first-word fall-through).
- Pop at edge N → next entry visible after edge N.
- `level_o` and flags are registered and update one edge after the event.
- `rx_rst_o` is registered:
  - Deasserts on the same edge that enters RUN, i.e. ARM_CYCLES edges after the first high sample if the line stays high.
  - Reasserts on the edge leaving RUN.

## Configuration
- `UART_RX_CTRL_ERRCNT_EN` defined: `frame_cnt_o`, `parity_cnt_o` and `overrun_cnt_o` are live.
  - Each increments on its error event: the flag-setting pulse, or a dropped character for overrun.
  - Each saturates at 255.
  - `clear_i` zeroes all three; an increment and a clear in the same cycle yields 1.
- Macro undefined: the counter ports remain and are tied to 0; no counter logic is built.

## Structure
- Package `uart_lite_pkg` holds:
  - the `rx_ctrl_state_t` enum (DISABLED, ARM, RUN);
  - the error counter width localparam (8).
- Sub-module `uart_rx_fifo`: parameterized storage, pointers, level, flush. It has push/pop/full/empty ports and no knowledge of the state machine.
- The top level contains the state machine, arm counter, sticky flags and error counters.

## Test plan
- Reset, raise `enable_i`, hold `rx_i`=1 → `rx_rst_o` falls after exactly 160 cycles. Repeat with a single low sample at cycle 100 → `rx_rst_o` falls 160 cycles after that sample.
- In RUN, push 0xA5, 0x3C with `data_ready_i`=0 → `level_o`=2, `data_o`=0xA5. Raise `data_ready_i` → 0x3C, then empty.
- Push 5 chars into a depth-4 FIFO with no reads → first 4 retained, `overrun_o`=1, `overrun_cnt_o`=1 (macro on) or 0 (macro off). Full + pop + push in the same cycle → no overrun.
- `frame_error_i` and `clear_i` in the same cycle → `frame_err_o`=1. Next-cycle `clear_i` → 0. Pulse `parity_error_i` 300 times → `parity_cnt_o`=255.
- Drop `enable_i` mid-stream → `rx_rst_o`=1 next cycle, later `valid_i` ignored, existing entries still readable. `flush_i` with a simultaneous push → `level_o`=0.
- Assert `rst_ni` low mid-RUN with a non-empty FIFO → all outputs take reset values asynchronously.

Source files
------------

// File: rtl/uart_lite_pkg.sv
// Shared types for the UART receive controller.
// Holds the controller state enum and error counter helpers.
package uart_lite_pkg;

  typedef enum logic [1:0] {
    DISABLED,
    ARM,
    RUN
  } rx_ctrl_state_t;

  localparam int ERR_CNT_W = 8;

  // Saturating error counter step; an increment beats a clear.
  function automatic logic [ERR_CNT_W-1:0] err_cnt_next(
    input logic [ERR_CNT_W-1:0] cnt,
    input logic                 inc,
    input logic                 clr
  );
    logic [ERR_CNT_W-1:0] res;
    res = cnt;
    if (clr && inc) begin
      res = ERR_CNT_W'(1);
    end else if (clr) begin
      res = '0;
    end else if (inc && (cnt != {ERR_CNT_W{1'b1}})) begin
      res = cnt + ERR_CNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word fall-through FIFO for received characters.
// Flush wins over a same-cycle push and pop.
module uart_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_level == FULL_LVL);
  assign empty_o = (r_level == '0);
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign level_o = r_level;
  assign data_o  = empty_o ? '0 : r_mem[r_rd];

  // Character storage; a flushed push is not written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !flush_i) begin
      r_mem[r_wr] <= data_i;
    end
  end

  // Pointers wrap naturally; level tracks push minus pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else if (flush_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop) begin
        r_level <= r_level + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: arming FSM, character FIFO, error status.
// Define UART_RX_CTRL_ERRCNT_EN to build the saturating error counters.
module uart_rx_ctrl
  import uart_lite_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ARM_CYCLES = 160
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          flush_i,
  input  logic                          clear_i,
  input  logic                          rx_i,
  input  logic [DATA_BITS-1:0]          char_i,
  input  logic                          valid_i,
  input  logic                          frame_error_i,
  input  logic                          parity_error_i,
  output logic                          rx_rst_o,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          data_valid_o,
  input  logic                          data_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overrun_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic [ERR_CNT_W-1:0]          frame_cnt_o,
  output logic [ERR_CNT_W-1:0]          parity_cnt_o,
  output logic [ERR_CNT_W-1:0]          overrun_cnt_o
);

  localparam int CW = $clog2(ARM_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(ARM_CYCLES - 1);

  rx_ctrl_state_t r_state;
  rx_ctrl_state_t w_state_nx;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nx;
  logic           r_rx_rst;
  logic           r_overrun;
  logic           r_frame;
  logic           r_parity;
  logic           w_run;
  logic           w_push;
  logic           w_full;
  logic           w_empty;
  logic           w_drop;
  logic           w_frame_ev;
  logic           w_parity_ev;

  // Next state and idle counter for the arming sequence.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      DISABLED: begin
        if (enable_i) begin
          w_state_nx = ARM;
          w_cnt_nx   = '0;
        end
      end
      ARM: begin
        if (!enable_i) begin
          w_state_nx = DISABLED;
        end else if (!rx_i) begin
          w_cnt_nx = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = RUN;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      RUN: begin
        if (!enable_i) w_state_nx = DISABLED;
      end
      default: begin
        w_state_nx = DISABLED;
      end
    endcase
  end

  // State, counter and the registered recovery-block reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= DISABLED;
      r_cnt    <= '0;
      r_rx_rst <= 1'b1;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_rx_rst <= (w_state_nx != RUN);
    end
  end

  assign w_run       = (r_state == RUN);
  assign w_push      = w_run && enable_i && valid_i;
  assign w_frame_ev  = w_run && frame_error_i;
  assign w_parity_ev = w_run && parity_error_i;
  assign w_drop      = w_push && w_full && !data_ready_i && !flush_i;

  uart_rx_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (data_ready_i),
    .flush_i (flush_i),
    .data_i  (char_i),
    .data_o  (data_o),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  assign data_valid_o = !w_empty;
  assign rx_rst_o     = r_rx_rst;

  // Sticky status flags; a set beats a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overrun <= 1'b0;
      r_frame   <= 1'b0;
      r_parity  <= 1'b0;
    end else begin
      r_overrun <= w_drop      || (r_overrun && !clear_i);
      r_frame   <= w_frame_ev  || (r_frame   && !clear_i);
      r_parity  <= w_parity_ev || (r_parity  && !clear_i);
    end
  end

  assign overrun_o    = r_overrun;
  assign frame_err_o  = r_frame;
  assign parity_err_o = r_parity;

`ifdef UART_RX_CTRL_ERRCNT_EN
  logic [ERR_CNT_W-1:0] r_frame_cnt;
  logic [ERR_CNT_W-1:0] r_parity_cnt;
  logic [ERR_CNT_W-1:0] r_overrun_cnt;

  // Saturating error event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_frame_cnt   <= '0;
      r_parity_cnt  <= '0;
      r_overrun_cnt <= '0;
    end else begin
      r_frame_cnt   <= err_cnt_next(r_frame_cnt, w_frame_ev, clear_i);
      r_parity_cnt  <= err_cnt_next(r_parity_cnt, w_parity_ev, clear_i);
      r_overrun_cnt <= err_cnt_next(r_overrun_cnt, w_drop, clear_i);
    end
  end

  assign frame_cnt_o   = r_frame_cnt;
  assign parity_cnt_o  = r_parity_cnt;
  assign overrun_cnt_o = r_overrun_cnt;
`else
  assign frame_cnt_o   = '0;
  assign parity_cnt_o  = '0;
  assign overrun_cnt_o = '0;
`endif

endmodule
